line_fill_responder: RTL and testbench

Backing-memory responder for the CachedRAM line interface. It serves cache line fills (read bursts) and line write-backs (write bursts) from an internal word-addressed array of 2^ADDR_WIDTH words. It sits below the cache controller and models main memory with a programmable access latency. The cache controller is the initiator; this block is the responder end of the same request/burst interface.

---
 rtl/line_fill_responder.sv | 153 +++++++++++++++
 tb/tb_line_fill_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_responder.sv
// line_fill_responder: backing-memory responder for cache line fills and write-backs.
// It holds a word-addressed array of 2^ADDR_WIDTH words. A read request waits
// LATENCY cycles and then returns LINE_WORDS registered beats. A write request
// takes LINE_WORDS beats, and the initiator may stall between them.
// Optional feature macro: BURST_WRAP_EN enables critical-word-first wrap ordering.
module line_fill_responder #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 2,
  parameter int OFF_W      = $clog2(LINE_WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  busy
);

  localparam int LINE_W = ADDR_WIDTH - OFF_W;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
  localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(LATENCY - 1);

`ifdef BURST_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RBURST,
    S_WBURST
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [LINE_W-1:0]     r_line;
  logic [OFF_W-1:0]      r_start;
  logic [OFF_W-1:0]      r_beat;
  logic [LAT_W-1:0]      r_lat_cnt;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_rd_last;
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic [OFF_W-1:0]      w_start_in;
  logic [OFF_W-1:0]      w_off;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_wr_fire;

  // The word offset is only OFF_W bits wide. Any carry is dropped, so a burst
  // wraps inside its own line and never reaches the tag bits.
  assign w_start_in = WRAP_EN ? req_addr[OFF_W-1:0] : '0;
  assign w_off      = r_start + r_beat;
  assign w_addr     = {r_line, w_off};
  assign w_wr_fire  = wr_valid && wr_ready;

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign rd_last  = r_rd_last;

  // Next-state logic and the handshake outputs that depend only on the state.
  // NOTE: every output is given a default first so that no path through the case infers a latch.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) w_next = req_write ? S_WBURST : S_WAIT;
      end
      S_WAIT: begin
        if (r_lat_cnt == '0) w_next = S_RBURST;
      end
      S_RBURST: begin
        if (r_beat == LAST_BEAT) w_next = S_IDLE;
      end
      S_WBURST: begin
        wr_ready = 1'b1;
        if (wr_valid && (r_beat == LAST_BEAT)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register. A low reset aborts any burst that is in progress.
  // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Request capture, the latency and beat counters, and the registered fill beat.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_line     <= '0;
      r_start    <= '0;
      r_beat     <= '0;
      r_lat_cnt  <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_line    <= req_addr[ADDR_WIDTH-1:OFF_W];
            r_start   <= w_start_in;
            r_beat    <= '0;
            r_lat_cnt <= LAT_INIT;
          end
        end
        S_WAIT: begin
          if (r_lat_cnt != '0) r_lat_cnt <= r_lat_cnt - 1'b1;
        end
        S_RBURST: begin
          r_rd_valid <= 1'b1;
          r_rd_last  <= (r_beat == LAST_BEAT);
          r_rd_data  <= r_mem[w_addr];
          r_beat     <= r_beat + 1'b1;
        end
        S_WBURST: begin
          if (wr_valid) r_beat <= r_beat + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Array write port. A write-back beat lands here on the edge that accepts it.
  // NOTE: the memory array has no reset. Its contents are meant to survive a reset.
  always_ff @(posedge clk) begin
    if (reset && w_wr_fire) r_mem[w_addr] <= wr_data;
  end

endmodule

// File: tb/tb_line_fill_responder.sv
// tb_line_fill_responder: randomized self-checking bench for line_fill_responder.
// A flat array model of memory predicts every fill beat. The model uses plain
// line/offset arithmetic for the beat order.
module tb_line_fill_responder;

  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int LW  = 4;
  localparam int LAT = 2;
  localparam int NLINES = (1 << AW) / LW;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_last;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  bit            line_ok   [0:NLINES-1];

  always #5 clk = ~clk;

  line_fill_responder #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LINE_WORDS(LW),
    .LATENCY   (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_last  (rd_last),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Index of the first word of the burst within its line.
  function automatic int start_of(input logic [AW-1:0] a);
`ifdef BURST_WRAP_EN
    return int'(a) % LW;
`else
    return 0;
`endif
  endfunction

  // Word address of beat i. The beat stays inside the line that holds address a.
  function automatic int beat_addr(input logic [AW-1:0] a, input int i);
    return (int'(a) / LW) * LW + (start_of(a) + i) % LW;
  endfunction

  // Presents a request and holds it until the responder takes it.
  // The task returns 1 ns after the accepting edge.
  task automatic accept(input bit wr, input logic [AW-1:0] a);
    bit done;
    bit rdy;
    done = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    for (int t = 0; t < 100 && !done; t++) begin
      rdy = req_ready;
      @(posedge clk);
      if (rdy) done = 1'b1;
      else     @(negedge clk);
    end
    #1 req_valid = 1'b0;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic write_line(input logic [AW-1:0] a, input logic [DW-1:0] d [LW],
                            input int stall_after, input int stall_len);
    accept(1'b1, a);
    for (int i = 0; i < LW; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = d[i];
      check("wr_ready_beat", wr_ready, 1);
      check("wr_busy_beat", busy, 1);
      @(posedge clk);
      #1 wr_valid = 1'b0;
      model_mem[beat_addr(a, i)] = d[i];
      if (i == stall_after) begin
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          wr_valid = 1'b0;
          wr_data  = DW'($urandom);
          check("stall_busy", busy, 1);
          check("stall_wr_ready", wr_ready, 1);
        end
      end
    end
    @(negedge clk);
    check("wr_done_ready", wr_ready, 0);
    check("wr_done_busy", busy, 0);
    check("wr_done_req_ready", req_ready, 1);
    line_ok[int'(a) / LW] = 1'b1;
  endtask

  // Observes a fill that was accepted on the edge just before the call.
  // Step k is the falling edge that follows accept_edge + k.
  task automatic fill_observe(input logic [AW-1:0] a, input int first_k);
    int i;
    for (int k = first_k; k <= LAT + LW + 1; k++) begin
      @(negedge clk);
      if (k <= LAT) begin
        check("lat_rd_valid", rd_valid, 0);
      end else if (k <= LAT + LW) begin
        i = k - LAT - 1;
        check("rd_valid", rd_valid, 1);
        check("rd_data", rd_data, model_mem[beat_addr(a, i)]);
        check("rd_last", rd_last, (i == LW - 1));
      end else begin
        check("rd_valid_drop", rd_valid, 0);
        check("rd_last_drop", rd_last, 0);
      end
      if (k < LAT + LW) begin
        check("fill_req_ready", req_ready, 0);
        check("fill_busy", busy, 1);
      end else if (k == LAT + LW) begin
        check("fill_end_req_ready", req_ready, 1);
      end
    end
  endtask

  task automatic fill_line(input logic [AW-1:0] a);
    accept(1'b0, a);
    fill_observe(a, 0);
  endtask

  task automatic write_random(input logic [AW-1:0] a);
    logic [DW-1:0] d [LW];
    for (int i = 0; i < LW; i++) d[i] = DW'($urandom);
    write_line(a, d, int'($urandom_range(0, LW - 2)), int'($urandom_range(0, 2)));
  endtask

  initial begin
    logic [DW-1:0] d [LW];
    logic [AW-1:0] a;
    int            line;

    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    wr_data   = '0;
    wr_valid  = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;

    // Put known contents in the low lines so that later fills can be checked.
    for (int l = 0; l < 16; l++) write_random(AW'(l * LW));

    // Write-back FF..FC to line 0x10, then fill it back.
    d[0] = 8'hFF; d[1] = 8'hFE; d[2] = 8'hFD; d[3] = 8'hFC;
    write_line(8'h10, d, -1, 0);
    fill_line(8'h10);

    // Write-back to 0x20 with a two-cycle stall after beat 1.
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    write_line(8'h20, d, 1, 2);
    fill_line(8'h20);

    // Hold a second request during a fill. It must be taken on the first IDLE edge.
    accept(1'b0, 8'h10);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h20;
    fill_observe(8'h10, 0);
    check("held_req_taken_busy", busy, 1);
    check("held_req_taken_ready", req_ready, 0);
    req_valid = 1'b0;
    fill_observe(8'h20, 1);

    // Reset on the second fill beat aborts the burst. A later fill is complete.
    accept(1'b0, 8'h20);
    for (int k = 0; k <= LAT + 2; k++) @(negedge clk);
    check("pre_rst_beat1", rd_data, model_mem[beat_addr(8'h20, 1)]);
    reset = 1'b0;
    @(negedge clk);
    check("abort_rd_valid", rd_valid, 0);
    check("abort_req_ready", req_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_rd_data", rd_data, 0);
    check("abort_wr_ready", wr_ready, 0);
    reset = 1'b1;
    fill_line(8'h20);

    // Fill of 0x12 on a line holding A0..A3. Ordering depends on BURST_WRAP_EN.
    d[0] = 8'hA0; d[1] = 8'hA1; d[2] = 8'hA2; d[3] = 8'hA3;
    write_line(8'h10, d, -1, 0);
    fill_line(8'h12);

    // The last line must not alias line 0.
    d[0] = 8'h5A; d[1] = 8'hC3; d[2] = 8'h96; d[3] = 8'h0F;
    write_line(8'hFC, d, 0, 1);
    fill_line(8'h00);
    fill_line(8'hFC);

    // Randomized mix of write-backs and fills at arbitrary word addresses.
    for (int n = 0; n < 40; n++) begin
      line = int'($urandom_range(0, NLINES - 1));
      a    = AW'(line * LW + int'($urandom_range(0, LW - 1)));
      if (!line_ok[line] || ($urandom_range(0, 1) == 0)) write_random(a);
      else                                               fill_line(a);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
